multi_cycle_control: RTL and testbench

MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

---
 rtl/multi_cycle_control_pkg.sv | 93 +++++++++
 rtl/multi_cycle_control_decoder.sv | 74 +++++++
 rtl/multi_cycle_control.sv | 89 ++++++++
 tb/tb_multi_cycle_control.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS-style control unit: FSM states, opcodes,
// datapath select codes and the opcode classifier.
package multi_cycle_control_pkg;

  typedef enum logic [2:0] {
    StIf  = 3'b000,
    StId  = 3'b001,
    StExe = 3'b010,
    StMem = 3'b011,
    StWb  = 3'b100
  } state_e;

  typedef enum logic [2:0] {
    ClsArith,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJump,
    ClsHalt
  } op_class_e;

  localparam logic [5:0] OpAdd         = 6'b000000;
  localparam logic [5:0] OpSub         = 6'b000001;
  localparam logic [5:0] OpAddiu       = 6'b000010;
  localparam logic [5:0] OpAnd         = 6'b010000;
  localparam logic [5:0] OpAndi        = 6'b010001;
  localparam logic [5:0] OpOri         = 6'b010010;
  localparam logic [5:0] OpSlt         = 6'b100110;
  localparam logic [5:0] OpSlti        = 6'b100111;
  localparam logic [5:0] OpSw          = 6'b110000;
  localparam logic [5:0] OpLw          = 6'b110001;
  localparam logic [5:0] OpBeq         = 6'b110100;
  localparam logic [5:0] OpBne         = 6'b110101;
  localparam logic [5:0] OpBltz        = 6'b110110;
  localparam logic [5:0] OpJ           = 6'b111000;
  localparam logic [5:0] OpJr          = 6'b111001;
  localparam logic [5:0] OpJal         = 6'b111010;
  localparam logic [5:0] OpHaltDefault = 6'b111111;

  localparam logic [1:0] PcPlus4  = 2'b00;
  localparam logic [1:0] PcBranch = 2'b01;
  localparam logic [1:0] PcReg    = 2'b10;
  localparam logic [1:0] PcJump   = 2'b11;

  localparam logic [1:0] RdRt = 2'b00;
  localparam logic [1:0] RdRd = 2'b01;
  localparam logic [1:0] RdRa = 2'b10;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluAnd = 3'b100;
  localparam logic [2:0] AluSlt = 3'b110;

  typedef struct packed {
    logic       pc_wre;
    logic [1:0] pc_src;
    logic       ir_wre;
    logic       ins_mem_rw;
    logic       reg_wre;
    logic       m_rd;
    logic       m_wr;
    logic       ext_sel;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       db_data_src;
    logic [1:0] reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;

  // Halt match wins over every other decode; unknown opcodes become jump-class nops.
  function automatic op_class_e op_class(input logic [5:0] op, input logic [5:0] halt_op);
    if (op == halt_op) return ClsHalt;
    case (op)
      OpAdd, OpSub, OpAddiu, OpAnd, OpAndi, OpOri, OpSlt, OpSlti: return ClsArith;
      OpLw:                                                       return ClsLoad;
      OpSw:                                                       return ClsStore;
      OpBeq, OpBne, OpBltz:                                       return ClsBranch;
      default:                                                    return ClsJump;
    endcase
  endfunction

  function automatic logic [2:0] alu_op_of(input logic [5:0] op);
    case (op)
      OpSub, OpBeq, OpBne, OpBltz: return AluSub;
      OpOri:                       return AluOr;
      OpAnd, OpAndi:               return AluAnd;
      OpSlt, OpSlti:               return AluSlt;
      default:                     return AluAdd;
    endcase
  endfunction

endpackage

// File: rtl/multi_cycle_control_decoder.sv
// Combinational datapath decode from FSM state and opcode; zero/sign only steer PCSrc in EXE.
module control_decoder
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0] HaltOp = OpHaltDefault
) (
  input  state_e      i_state,
  input  logic [5:0]  i_opcode,
  input  logic        i_zero,
  input  logic        i_sign,
  output ctrl_t       o_ctrl
);

  op_class_e w_class;
  logic      w_taken;
  logic      w_imm;
  logic      w_r_type;

  always_comb begin
    w_class  = op_class(i_opcode, HaltOp);
    w_taken  = ((i_opcode == OpBeq) & i_zero) | ((i_opcode == OpBne) & ~i_zero) |
               ((i_opcode == OpBltz) & i_sign);
    w_imm    = i_opcode inside {OpAddiu, OpAndi, OpOri, OpSlti, OpLw, OpSw};
    w_r_type = i_opcode inside {OpAdd, OpSub, OpAnd, OpSlt};

    o_ctrl = '0;
    case (i_state)
      StIf: begin
        o_ctrl.ir_wre     = 1'b1;
        o_ctrl.ins_mem_rw = 1'b1;
      end
      StId: begin
        if (w_class == ClsJump) begin
          o_ctrl.pc_wre = 1'b1;
          case (i_opcode)
            OpJ:  o_ctrl.pc_src = PcJump;
            OpJr: o_ctrl.pc_src = PcReg;
            OpJal: begin
              o_ctrl.pc_src  = PcJump;
              o_ctrl.reg_wre = 1'b1;
              o_ctrl.reg_dst = RdRa;
            end
            default: o_ctrl.pc_src = PcPlus4;
          endcase
        end
      end
      StExe: begin
        o_ctrl.alu_op    = alu_op_of(i_opcode);
        o_ctrl.ext_sel   = !(i_opcode inside {OpAndi, OpOri});
        o_ctrl.alu_src_b = w_imm;
        if (w_class == ClsBranch) begin
          o_ctrl.pc_wre = 1'b1;
          o_ctrl.pc_src = w_taken ? PcBranch : PcPlus4;
        end
      end
      StMem: begin
        if (w_class == ClsStore) begin
          o_ctrl.m_wr   = 1'b1;
          o_ctrl.pc_wre = 1'b1;
        end else if (w_class == ClsLoad) begin
          o_ctrl.m_rd = 1'b1;
        end
      end
      StWb: begin
        o_ctrl.reg_wre     = 1'b1;
        o_ctrl.pc_wre      = 1'b1;
        o_ctrl.db_data_src = (w_class == ClsLoad);
        o_ctrl.reg_dst     = w_r_type ? RdRd : RdRt;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle control FSM: state register and sequencing, datapath decode in control_decoder.
module multi_cycle_control
  import multi_cycle_control_pkg::*;
#(
  parameter logic [5:0]  HALT_OP  = 6'b111111,
  parameter int unsigned ALU_OP_W = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [5:0]          opcode,
  input  logic                zero,
  input  logic                sign,
  output logic [2:0]          State,
  output logic                PCWre,
  output logic [1:0]          PCSrc,
  output logic                IRWre,
  output logic                InsMemRW,
  output logic                RegWre,
  output logic                mRD,
  output logic                mWR,
  output logic                ExtSel,
  output logic                ALUSrcA,
  output logic                ALUSrcB,
  output logic                DBDataSrc,
  output logic [1:0]          RegDst,
  output logic [ALU_OP_W-1:0] ALUOp
);

  state_e    r_state;
  state_e    w_next_state;
  op_class_e w_class;
  ctrl_t     w_ctrl;

  always_comb begin
    w_class      = op_class(opcode, HALT_OP);
    w_next_state = StIf;
    case (r_state)
      StIf: w_next_state = StId;
      StId: begin
        case (w_class)
          ClsJump: w_next_state = StIf;
          ClsHalt: w_next_state = StId;
          default: w_next_state = StExe;
        endcase
      end
      StExe: begin
        case (w_class)
          ClsBranch:         w_next_state = StIf;
          ClsLoad, ClsStore: w_next_state = StMem;
          default:           w_next_state = StWb;
        endcase
      end
      StMem:   w_next_state = (w_class == ClsLoad) ? StWb : StIf;
      StWb:    w_next_state = StIf;
      default: w_next_state = StIf;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= StIf;
    else      r_state <= w_next_state;
  end

  control_decoder #(
    .HaltOp (HALT_OP)
  ) u_decoder (
    .i_state  (r_state),
    .i_opcode (opcode),
    .i_zero   (zero),
    .i_sign   (sign),
    .o_ctrl   (w_ctrl)
  );

  assign State     = r_state;
  assign PCWre     = w_ctrl.pc_wre;
  assign PCSrc     = w_ctrl.pc_src;
  assign IRWre     = w_ctrl.ir_wre;
  assign InsMemRW  = w_ctrl.ins_mem_rw;
  assign RegWre    = w_ctrl.reg_wre;
  assign mRD       = w_ctrl.m_rd;
  assign mWR       = w_ctrl.m_wr;
  assign ExtSel    = w_ctrl.ext_sel;
  assign ALUSrcA   = w_ctrl.alu_src_a;
  assign ALUSrcB   = w_ctrl.alu_src_b;
  assign DBDataSrc = w_ctrl.db_data_src;
  assign RegDst    = w_ctrl.reg_dst;
  assign ALUOp     = ALU_OP_W'(w_ctrl.alu_op);

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: directed scenarios plus randomized
// instruction streams compared against a per-instruction timing/output model.
module tb_multi_cycle_control;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDIU = 6'b000010;
  localparam logic [5:0] AND = 6'b010000, ANDI = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLT = 6'b100110, SLTI = 6'b100111, SW = 6'b110000;
  localparam logic [5:0] LW = 6'b110001, BEQ = 6'b110100, BNE = 6'b110101;
  localparam logic [5:0] BLTZ = 6'b110110, J = 6'b111000, JR = 6'b111001;
  localparam logic [5:0] JAL = 6'b111010, HALT = 6'b111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [5:0] opcode = ADD;
  logic       zero = 1'b0;
  logic       sign = 1'b0;
  logic [2:0] State;
  logic       PCWre, IRWre, InsMemRW, RegWre, mRD, mWR, ExtSel, ALUSrcA, ALUSrcB, DBDataSrc;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp;
  logic [16:0] outs;

  int checks = 0;
  int errors = 0;

  multi_cycle_control dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign), .State(State),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .InsMemRW(InsMemRW), .RegWre(RegWre),
    .mRD(mRD), .mWR(mWR), .ExtSel(ExtSel), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .RegDst(RegDst), .ALUOp(ALUOp)
  );

  always #5 CLK = ~CLK;

  assign outs = {PCWre, PCSrc, IRWre, InsMemRW, RegWre, mRD, mWR, ExtSel, ALUSrcA, ALUSrcB,
                 DBDataSrc, RegDst, ALUOp};

  // Cycles per instruction; 0 means the instruction never completes (halt).
  function automatic int latency(input logic [5:0] op);
    case (op)
      HALT:                                       return 0;
      BEQ, BNE, BLTZ:                             return 3;
      SW, ADD, SUB, ADDIU, AND, ANDI, ORI, SLT, SLTI: return 4;
      LW:                                         return 5;
      default:                                    return 2;
    endcase
  endfunction

  function automatic logic [2:0] exp_state(input logic [5:0] op, input int k);
    if (k <= 2) return 3'(k);
    if (k == 3 && (op == SW || op == LW)) return 3'b011;
    return 3'b100;
  endfunction

  // Expected output vector in cycle k of an instruction (same bit order as outs).
  function automatic logic [16:0] exp_outs(input logic [5:0] op, input int k, input logic z,
                                           input logic s);
    logic [16:0] e;
    int lat;
    e   = '0;
    lat = latency(op);
    if (k == 0) begin
      e[13] = 1'b1;
      e[12] = 1'b1;
    end
    if (lat != 0 && k == lat - 1) e[16] = 1'b1;
    if (lat == 2 && k == 1) begin
      if (op == J || op == JAL) e[15:14] = 2'b11;
      if (op == JR) e[15:14] = 2'b10;
      if (op == JAL) begin
        e[11]  = 1'b1;
        e[4:3] = 2'b10;
      end
    end
    if (lat >= 3 && k == 2) begin
      case (op)
        SUB, BEQ, BNE, BLTZ: e[2:0] = 3'b001;
        ORI:                 e[2:0] = 3'b011;
        AND, ANDI:           e[2:0] = 3'b100;
        SLT, SLTI:           e[2:0] = 3'b110;
        default:             e[2:0] = 3'b000;
      endcase
      e[8] = !(op == ANDI || op == ORI);
      e[6] = op inside {ADDIU, ANDI, ORI, SLTI, LW, SW};
      if (lat == 3)
        e[15:14] = (((op == BEQ) && z) || ((op == BNE) && !z) || ((op == BLTZ) && s)) ?
                   2'b01 : 2'b00;
    end
    if (k == 3 && op == SW) e[9] = 1'b1;
    if (k == 3 && op == LW) e[10] = 1'b1;
    if ((lat == 4 && op != SW && k == 3) || (op == LW && k == 4)) begin
      e[11]  = 1'b1;
      e[5]   = (op == LW);
      e[4:3] = (op inside {ADD, SUB, AND, SLT}) ? 2'b01 : 2'b00;
    end
    return e;
  endfunction

  // Leaves the bench one time unit after a rising edge with the FSM in IF.
  task automatic apply_reset();
    RST = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic test_reset();
    RST    = 1'b0;
    opcode = ADD;
    #1;
    checks++;
    if (State !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000", State);
    end
    checks++;
    if (outs !== 17'h03000) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", outs, 17'h03000);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (State !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 000", State);
    end
    RST = 1'b1;
  endtask

  task automatic test_arith();
    logic [2:0] seq [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    opcode = ADD;
    for (int k = 0; k < 4; k++) begin
      zero = 1'($urandom);
      sign = 1'($urandom);
      @(negedge CLK);
      checks++;
      if (State !== seq[k]) begin
        errors++;
        $display("FAIL arith_state[%0d]: got %b expected %b", k, State, seq[k]);
      end
      checks++;
      if ({PCWre, RegWre} !== {(k == 3), (k == 3)}) begin
        errors++;
        $display("FAIL arith_wre[%0d]: got %b%b expected %b%b", k, PCWre, RegWre, k == 3,
                 k == 3);
      end
      @(posedge CLK);
      #1;
    end
    checks++;
    if (State !== 3'b000) begin
      errors++;
      $display("FAIL arith_return: got %b expected 000", State);
    end
  endtask

  task automatic test_lw();
    logic [2:0] seq [5] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
    opcode = LW;
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      checks++;
      if (State !== seq[k]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %b expected %b", k, State, seq[k]);
      end
      checks++;
      if ({mRD, DBDataSrc, PCWre} !== {(k == 3), (k == 4), (k == 4)}) begin
        errors++;
        $display("FAIL lw_ctrl[%0d]: got %b%b%b", k, mRD, DBDataSrc, PCWre);
      end
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_beq();
    for (int t = 0; t < 2; t++) begin
      opcode = BEQ;
      zero   = (t == 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge CLK);
        checks++;
        if (State !== 3'(k)) begin
          errors++;
          $display("FAIL beq_state[%0d]: got %b expected %0d", k, State, k);
        end
        if (k == 2) begin
          checks++;
          if ({PCWre, PCSrc} !== {1'b1, (t == 0) ? 2'b01 : 2'b00}) begin
            errors++;
            $display("FAIL beq_pc zero=%b: got %b/%b", zero, PCWre, PCSrc);
          end
        end
        @(posedge CLK);
        #1;
      end
      checks++;
      if (State !== 3'b000) begin
        errors++;
        $display("FAIL beq_return: got %b expected 000", State);
      end
    end
  endtask

  task automatic test_jal();
    opcode = JAL;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    checks++;
    if ({State, RegWre, RegDst, PCSrc, PCWre} !== {3'b001, 1'b1, 2'b10, 2'b11, 1'b1}) begin
      errors++;
      $display("FAIL jal_id: got st=%b rw=%b rd=%b src=%b pw=%b", State, RegWre, RegDst,
               PCSrc, PCWre);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (State !== 3'b000) begin
      errors++;
      $display("FAIL jal_return: got %b expected 000", State);
    end
  endtask

  task automatic test_reset_mid();
    opcode = ADD;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({State, RegWre} !== 4'b1001) begin
      errors++;
      $display("FAIL mid_wb_reach: got st=%b rw=%b", State, RegWre);
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({State, RegWre, PCWre} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_wb_abort: got st=%b rw=%b pw=%b", State, RegWre, PCWre);
    end
    #3 RST = 1'b1;
    @(posedge CLK);
    #1;
    checks++;
    if (State !== 3'b001) begin
      errors++;
      $display("FAIL first_edge_after_reset: got %b expected 001", State);
    end
    apply_reset();
    opcode = SW;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
    checks++;
    if ({State, mWR, PCWre} !== 5'b00000) begin
      errors++;
      $display("FAIL mid_mem_abort: got st=%b mwr=%b pw=%b", State, mWR, PCWre);
    end
    apply_reset();
  endtask

  task automatic test_halt();
    opcode = HALT;
    @(posedge CLK);
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      checks++;
      if ({State, PCWre} !== 4'b0010) begin
        errors++;
        $display("FAIL halt_hold[%0d]: got st=%b pw=%b", c, State, PCWre);
      end
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
    #1;
    checks++;
    if (State !== 3'b000) begin
      errors++;
      $display("FAIL halt_reset: got %b expected 000", State);
    end
    opcode = ADD;
    @(posedge CLK);
    #1 RST = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] ops [16] = '{ADD, SUB, ADDIU, AND, ANDI, ORI, SLT, SLTI, SW, LW, BEQ, BNE,
                             BLTZ, J, JR, JAL};
    logic [5:0] op;
    int lat;
    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      if (op == HALT) op = JR;
      opcode = op;
      lat    = latency(op);
      for (int k = 0; k < lat; k++) begin
        zero = 1'($urandom);
        sign = 1'($urandom);
        @(negedge CLK);
        checks++;
        if ({State, outs} !== {exp_state(op, k), exp_outs(op, k, zero, sign)}) begin
          errors++;
          $display("FAIL random op=%b cyc=%0d: got st=%b out=%h expected st=%b out=%h", op,
                   k, State, outs, exp_state(op, k), exp_outs(op, k, zero, sign));
        end
        @(posedge CLK);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_lw();
    test_beq();
    test_jal();
    test_reset_mid();
    test_halt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
